// File: rtl/btn_conditioner.sv
// Pushbutton front end: per-button 2-FF synchroniser, 1 ms tick debounce FSM,
// registered clean level plus single-cycle press/release pulses.
// A change on the synchronised input is accepted only once it has held
// across DEBOUNCE_MS ticks; any reversion before that restarts the wait.
//
// state        | meaning
// -------------+------------------------------------------------------------
// RELEASED     | button idle, level 0
// PRESS_PEND   | input reads pressed, counting ticks before accepting press
// PRESSED      | button held, level 1
// RELEASE_PEND | input reads released, counting ticks before accepting release
module btn_conditioner #(
  parameter int N_BTN       = 5,
  parameter int DEBOUNCE_MS = 4,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_1ms,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);
  // raw pad value that means "not pressed"; also the synchroniser reset value
  localparam logic [N_BTN-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] btn_sync;
  logic             clk_1ms_d;
  logic             tick;

  // Two-stage synchroniser; no logic ahead of the first flop, polarity fixed after
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= RAW_IDLE;
      sync_q2 <= RAW_IDLE;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_sync = sync_q2 ^ RAW_IDLE;

  // Delay of the 1 ms square wave for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_1ms_d <= 1'b0;
    end else begin
      clk_1ms_d <= clk_1ms;
    end
  end

  assign tick = clk_1ms & ~clk_1ms_d;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_d;
    logic             release_d;
    logic             level_d;
    logic             press_q;
    logic             release_q;
    logic             level_q;

    // State, tick counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        level_q   <= level_d;
      end
    end

    // Next state: a bounce back always wins over a coincident tick
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (btn_sync[gi]) begin
            state_d = PRESS_PEND;
            cnt_d   = '0;
          end
        end
        PRESS_PEND: begin
          if (!btn_sync[gi]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d = PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        PRESSED: begin
          if (!btn_sync[gi]) begin
            state_d = RELEASE_PEND;
            cnt_d   = '0;
          end
        end
        RELEASE_PEND: begin
          if (btn_sync[gi]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_d   = RELEASED;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
      level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    end

    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_level[gi]   = level_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (5 buttons, 4 ms debounce, active-low pads,
// clk_1ms period of 20 clk). A reference model tracks each button as an
// accepted level plus a "pending change" tick count and is compared with the
// DUT on every falling clock edge; directed scenarios add literal checks.
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int MS = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         clk_1ms = 1'b0;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit stuck = 1'b0;
  int press_cnt[N];
  int rel_cnt[N];

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_MS(D), .ACTIVE_LOW(1)) dut (
    .clk(clk),
    .reset(reset),
    .clk_1ms(clk_1ms),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1 ms square wave: high for the first half of every 20-cycle frame
  initial forever begin
    @(negedge clk);
    clk_1ms = stuck ? 1'b0 : ((cyc % MS) < (MS / 2));
  end

  // ---------------- reference model ----------------
  // pressed view of the pad after two clocks, accepted level, and for each
  // button whether a change is pending and how many ticks it has survived
  logic [N-1:0] m_q1, m_q2, m_lvl, m_pend, m_press, m_rel;
  logic         m_d;
  int           m_ticks[N];
  wire          m_tick = clk_1ms & ~m_d;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q1 <= '0; m_q2 <= '0; m_lvl <= '0; m_pend <= '0;
      m_press <= '0; m_rel <= '0; m_d <= 1'b0;
      for (int i = 0; i < N; i++) m_ticks[i] <= 0;
    end else begin
      m_q1 <= ~btn_raw;
      m_q2 <= m_q1;
      m_d  <= clk_1ms;
      for (int i = 0; i < N; i++) begin
        m_press[i] <= 1'b0;
        m_rel[i]   <= 1'b0;
        if (!m_pend[i]) begin
          if (m_q2[i] != m_lvl[i]) begin
            m_pend[i]  <= 1'b1;
            m_ticks[i] <= 0;
          end
        end else if (m_q2[i] == m_lvl[i]) begin
          m_pend[i] <= 1'b0;
        end else if (m_tick) begin
          if (m_ticks[i] + 1 == D) begin
            m_lvl[i]   <= m_q2[i];
            m_pend[i]  <= 1'b0;
            m_press[i] <= m_q2[i];
            m_rel[i]   <= ~m_q2[i];
          end else begin
            m_ticks[i] <= m_ticks[i] + 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    checks++;
    if ({btn_level, btn_press, btn_release} !== {m_lvl, m_press, m_rel}) begin
      failures++;
      if (failures <= 20)
        $display("FAIL model_cmp cyc=%0d got lvl=%h prs=%h rel=%h expected lvl=%h prs=%h rel=%h",
                 cyc, btn_level, btn_press, btn_release, m_lvl, m_press, m_rel);
    end
  end

  // Pulse counters, sampled well clear of both clock edges
  initial begin
    for (int i = 0; i < N; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (btn_press[i])   press_cnt[i]++;
        if (btn_release[i]) rel_cnt[i]++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Wait (bounded) for a press or release pulse on any bit of mask
  task automatic wait_pulse(input logic [N-1:0] mask, input bit rel, output int lat);
    lat = 0;
    while (lat <= 120) begin
      @(negedge clk);
      lat++;
      if (((rel ? btn_release : btn_press) & mask) != '0) break;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (btn_level != '0 && n < 200) begin
      step(1);
      n++;
    end
    chk("idle_level", int'(btn_level), 0);
  endtask

  task automatic align(input int phase);
    while ((cyc % MS) != phase) step(1);
  endtask

  // Sync (2) + entry (1) + D counted ticks 20 apart, first at most 20 away
  localparam int LAT_LO = 3 + (D - 1) * MS + 1;
  localparam int LAT_HI = 3 + D * MS;

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int p0, r0;
    int nxt[N];

    // 1: reset with every pad pressed
    btn_raw = '0;
    step(5);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(btn_press), 0);
    chk("rst_release", int'(btn_release), 0);
    reset = 1'b1;
    wait_pulse('1, 1'b0, lat);
    chk_range("rst_exit_press_lat", lat, LAT_LO, LAT_HI);
    chk("rst_exit_press", int'(btn_press), 5'h1F);
    chk("rst_exit_level", int'(btn_level), 5'h1F);
    step(1);
    chk("rst_exit_pulse_width", int'(btn_press), 0);

    // 2: clean press on bit 0 only
    btn_raw = '1;
    wait_idle();
    step(7);
    btn_raw[0] = 1'b0;
    wait_pulse(5'h01, 1'b0, lat);
    chk_range("clean_lat", lat, LAT_LO, LAT_HI);
    chk("clean_press", int'(btn_press), 5'h01);
    chk("clean_level", int'(btn_level), 5'h01);
    step(1);
    chk("clean_pulse_width", int'(btn_press), 0);

    // 3: bit 1 bounces every 7 clk, then holds pressed
    p0 = press_cnt[1];
    for (int k = 0; k < 14; k++) begin
      btn_raw[1] = ~btn_raw[1];
      step(7);
    end
    btn_raw[1] = 1'b0;
    chk("bounce_no_press", press_cnt[1] - p0, 0);
    wait_pulse(5'h02, 1'b0, lat);
    chk_range("bounce_lat", lat, LAT_LO, LAT_HI);
    chk("bounce_press", int'(btn_press), 5'h02);

    // 4: short release on bit 2 is rejected, long one accepted
    btn_raw[2] = 1'b0;
    wait_pulse(5'h04, 1'b0, lat);
    chk_range("b2_press_lat", lat, LAT_LO, LAT_HI);
    step(3);
    r0 = rel_cnt[2];
    btn_raw[2] = 1'b1;
    step(2 * MS);
    btn_raw[2] = 1'b0;
    step(4 * MS);
    chk("short_rel_no_pulse", rel_cnt[2] - r0, 0);
    chk("short_rel_level", int'(btn_level[2]), 1);
    btn_raw[2] = 1'b1;
    wait_pulse(5'h04, 1'b1, lat);
    chk_range("rel_lat", lat, LAT_LO, LAT_HI);
    chk("rel_pulse", int'(btn_release), 5'h04);
    chk("rel_level", int'(btn_level[2]), 0);
    step(1);
    chk("rel_pulse_width", int'(btn_release), 0);

    // 5: simultaneous presses, then a glitch on bit 3 at the first tick
    btn_raw = '1;
    wait_idle();
    step(3);
    btn_raw = '0;
    wait_pulse('1, 1'b0, lat);
    chk("simul_press", int'(btn_press), 5'h1F);
    btn_raw = '1;
    wait_idle();
    align(5);
    btn_raw = '0;
    align(MS - 2);
    btn_raw[3] = 1'b1;
    step(1);
    btn_raw[3] = 1'b0;
    wait_pulse('1, 1'b0, lat);
    chk("glitch_others", int'(btn_press), 5'h17);
    wait_pulse(5'h08, 1'b0, lat);
    chk_range("glitch_b3_late", lat, 1, MS + 5);
    chk("glitch_b3_press", int'(btn_press), 5'h08);

    // 6: async reset mid press-pending on bit 4 while bit 0 is held
    btn_raw = '1;
    wait_idle();
    btn_raw[0] = 1'b0;
    wait_pulse(5'h01, 1'b0, lat);
    align(5);
    btn_raw[4] = 1'b0;
    step(2 * MS);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_level", int'(btn_level), 0);
    chk("async_rst_press", int'(btn_press), 0);
    chk("async_rst_release", int'(btn_release), 0);
    step(3);
    reset = 1'b1;
    wait_pulse(5'h11, 1'b0, lat);
    chk_range("post_rst_lat", lat, LAT_LO, LAT_HI);
    chk("post_rst_press", int'(btn_press), 5'h11);

    // 7: no ticks -> releases stay pending, level unchanged
    step(2);
    stuck = 1'b1;
    r0 = rel_cnt[0] + rel_cnt[4];
    btn_raw = '1;
    step(300);
    chk("stuck_level", int'(btn_level), 5'h11);
    chk("stuck_no_release", rel_cnt[0] + rel_cnt[4] - r0, 0);
    stuck = 1'b0;
    wait_idle();

    // 8: random bouncing / holding on all buttons, one async reset midway
    for (int i = 0; i < N; i++) nxt[i] = cyc + int'($urandom_range(1, 30));
    for (int t = 0; t < 4000; t++) begin
      step(1);
      for (int i = 0; i < N; i++) begin
        if (cyc >= nxt[i]) begin
          btn_raw[i] = ~btn_raw[i];
          nxt[i] = cyc + (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15))
                                                      : int'($urandom_range(60, 160)));
        end
      end
      if (t == 2000) begin
        @(posedge clk);
        #3 reset = 1'b0;
        step(2);
        reset = 1'b1;
      end
    end
    step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
